ghost_mode_scheduler: RTL and testbench

Global ghost-mode generator that drives the shared ghost-mode bus and the ghost release pulse. Every per-ghost state controller consumes these two signals.
- Runs the level's scatter/chase timetable.
- Overrides it with FRIGHTENED when a power pellet is eaten.
- Issues the one-cycle release pulse that moves ghosts out of idle.
- Sits beside the game-state FSM and is timed by the frame tick.

---
 rtl/ghost_mode_scheduler_pkg.sv | 39 +++
 rtl/ghost_mode_scheduler_if.sv | 20 ++
 rtl/ghost_mode_scheduler_tick_counter.sv | 38 +++
 rtl/ghost_mode_scheduler.sv | 97 +++++++++
 tb/tb_ghost_mode_scheduler.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/ghost_mode_scheduler_pkg.sv
// Shared ghost-mode definitions: game-state codes, global mode codes and
// the scatter/chase timetable helpers used by the scheduler and ghost controllers.
package ghost_mode_scheduler_pkg;

  typedef enum logic [7:0] {
    GS_IDLE     = 8'h00,
    GS_PLAY     = 8'h01,
    GS_PAUSE    = 8'h02,
    GS_RELOAD   = 8'h03,
    GS_CLEAR    = 8'h04,
    GS_GAMEOVER = 8'h05
  } game_state_e;

  typedef enum logic [3:0] {
    CHASE      = 4'd0,
    SCATTER    = 4'd1,
    FRIGHTENED = 4'd2
  } ghost_mode_e;

  localparam logic [2:0] LAST_PHASE = 3'd7;

  // Phase 7 is endless chase, so it has no duration.
  function automatic int unsigned phase_duration(input logic [2:0] phase,
                                                 input int unsigned scatter_long,
                                                 input int unsigned scatter_short,
                                                 input int unsigned chase_len);
    case (phase)
      3'd0, 3'd2:       return scatter_long;
      3'd4, 3'd6:       return scatter_short;
      3'd1, 3'd3, 3'd5: return chase_len;
      default:          return 0;
    endcase
  endfunction

  function automatic ghost_mode_e phase_mode(input logic [2:0] phase);
    return phase[0] ? CHASE : SCATTER;
  endfunction

endpackage

// File: rtl/ghost_mode_scheduler_if.sv
// Ghost-mode bus between the game logic (master) and the mode scheduler (slave).
interface ghost_mode_scheduler_if;
  logic [7:0] i_game_state;
  logic       i_tick;
  logic       i_power_pellet;
  logic [3:0] o_ghost_state;
  logic       o_ghost_reload;
  logic       o_fright_flash;
  logic [2:0] o_phase;

  modport master (
    output i_game_state, i_tick, i_power_pellet,
    input  o_ghost_state, o_ghost_reload, o_fright_flash, o_phase
  );

  modport slave (
    input  i_game_state, i_tick, i_power_pellet,
    output o_ghost_state, o_ghost_reload, o_fright_flash, o_phase
  );
endinterface

// File: rtl/ghost_mode_scheduler_tick_counter.sv
// Loadable down-counter with synchronous clear, stopping at zero.
// count_next exposes the value the counter takes at the next clock edge.
module ghost_tick_counter #(
  parameter int unsigned      CNT_W   = 12,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count_next,
  output logic             is_zero,
  output logic             is_one
);
  logic [CNT_W-1:0] count;

  always_comb begin
    count_next = count;
    if (clr)
      count_next = RST_VAL;
    else if (load)
      count_next = load_val;
    else if (dec && !is_zero)
      count_next = count - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= RST_VAL;
    else
      count <= count_next;
  end

  assign is_zero = (count == '0);
  assign is_one  = (count == CNT_W'(1));
endmodule

// File: rtl/ghost_mode_scheduler.sv
// Global ghost-mode generator: scatter/chase timetable, frightened override
// and the one-shot ghost release pulse, all advanced by the frame tick.
module ghost_mode_scheduler
  import ghost_mode_scheduler_pkg::*;
#(
  parameter int unsigned SCATTER_LONG  = 420,
  parameter int unsigned SCATTER_SHORT = 300,
  parameter int unsigned CHASE_LEN     = 1200,
  parameter int unsigned FRIGHT_LEN    = 360,
  parameter int unsigned FLASH_LEN     = 120,
  parameter int unsigned RELOAD_DELAY  = 120,
  parameter int unsigned CNT_W         = 12
) (
  input logic                   i_clk,
  input logic                   i_rst,
  ghost_mode_scheduler_if.slave bus
);
  logic             play, pause_st, clear;
  logic             released, run, pellet, retrigger;
  logic             rel_dec, rel_done, rel_one;
  logic             sched_dec, sched_one, sched_zero, advance;
  logic             fright_dec, fright_zero, fright_one;
  logic [CNT_W-1:0] sched_load_val, sched_next, rel_next, fright_next;
  logic [2:0]       phase, phase_next;
  ghost_mode_e      ghost_state;
  logic             reload, flash;

  assign play     = (bus.i_game_state == GS_PLAY);
  assign pause_st = (bus.i_game_state == GS_PAUSE);
  assign clear    = !play && !pause_st;

  always_comb begin
    run        = play && released;
    pellet     = run && bus.i_power_pellet;
    retrigger  = pellet && !fright_zero;
    rel_dec    = play && !released && bus.i_tick;
    rel_done   = rel_dec && rel_one;
    // Pellet-cycle ticks still count against the schedule, so a boundary
    // crossing on that cycle lands before the schedule freezes.
    sched_dec  = run && bus.i_tick && fright_zero && !sched_zero;
    advance    = sched_dec && sched_one && (phase != LAST_PHASE);
    phase_next = advance ? phase + 3'd1 : phase;
    fright_dec = run && bus.i_tick && !fright_zero && !pellet;
    sched_load_val = CNT_W'(phase_duration(phase_next, SCATTER_LONG,
                                           SCATTER_SHORT, CHASE_LEN));
  end

  ghost_tick_counter #(.CNT_W(CNT_W), .RST_VAL(CNT_W'(SCATTER_LONG))) u_sched (
    .clk(i_clk), .rst(i_rst), .clr(clear), .load(advance), .dec(sched_dec),
    .load_val(sched_load_val), .count_next(sched_next),
    .is_zero(sched_zero), .is_one(sched_one)
  );

  ghost_tick_counter #(.CNT_W(CNT_W), .RST_VAL('0)) u_fright (
    .clk(i_clk), .rst(i_rst), .clr(clear), .load(pellet), .dec(fright_dec),
    .load_val(CNT_W'(FRIGHT_LEN)), .count_next(fright_next),
    .is_zero(fright_zero), .is_one(fright_one)
  );

  // The release counter reaching zero is the "released" flag.
  ghost_tick_counter #(.CNT_W(CNT_W), .RST_VAL(CNT_W'(RELOAD_DELAY))) u_release (
    .clk(i_clk), .rst(i_rst), .clr(clear), .load(1'b0), .dec(rel_dec),
    .load_val('0), .count_next(rel_next),
    .is_zero(released), .is_one(rel_one)
  );

  logic unused_counter_outputs;
  assign unused_counter_outputs = ^{sched_next, rel_next, fright_one};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      phase       <= '0;
      ghost_state <= SCATTER;
      reload      <= 1'b0;
      flash       <= 1'b0;
    end else if (clear) begin
      phase       <= '0;
      ghost_state <= SCATTER;
      reload      <= 1'b0;
      flash       <= 1'b0;
    end else if (play) begin
      phase  <= phase_next;
      reload <= rel_done;
      // A re-trigger shows the schedule mode for one cycle before FRIGHTENED.
      ghost_state <= (fright_next != '0 && !retrigger) ? FRIGHTENED
                                                        : phase_mode(phase_next);
      flash <= (fright_next != '0) && (fright_next <= CNT_W'(FLASH_LEN));
    end else begin
      reload <= 1'b0;
    end
  end

  assign bus.o_ghost_state  = ghost_state;
  assign bus.o_ghost_reload = reload;
  assign bus.o_fright_flash = flash;
  assign bus.o_phase        = phase;
endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Directed bench for ghost_mode_scheduler with shortened timetable durations.
module tb_ghost_mode_scheduler;
  import ghost_mode_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [8:0]  obs;
  int          cum [7] = '{4, 10, 14, 20, 23, 29, 32};
  logic        fl_exp [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  ghost_mode_scheduler_if bus();

  ghost_mode_scheduler #(
    .SCATTER_LONG(4), .SCATTER_SHORT(3), .CHASE_LEN(6), .FRIGHT_LEN(5),
    .FLASH_LEN(2), .RELOAD_DELAY(2), .CNT_W(12)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // {mode, reload, flash, phase}
  assign obs = {bus.o_ghost_state, bus.o_ghost_reload, bus.o_fright_flash, bus.o_phase};

  function automatic logic [8:0] ev(input ghost_mode_e m, input logic r,
                                    input logic f, input logic [2:0] p);
    return {m, r, f, p};
  endfunction

  task automatic chk(input string tag, input logic [8:0] o, input logic [8:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed mode/rl/fl/ph=%h expected %h", tag, o, e);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_game_state   = GS_IDLE;
    bus.i_tick         = 1'b1;
    bus.i_power_pellet = 1'b0;
    #12;
    chk("reset", obs, ev(SCATTER, 1'b0, 1'b0, 3'd0));
    @(negedge clk);
    rst = 1'b0;

    // IDLE holds everything; ticks and pellets ignored
    bus.i_power_pellet = 1'b1;
    cycle();
    bus.i_power_pellet = 1'b0;
    cycle();
    chk("idle_hold", obs, ev(SCATTER, 1'b0, 1'b0, 3'd0));

    // Release: pulse after two PLAY ticks
    bus.i_game_state = GS_PLAY;
    cycle();
    chk("rel_tick1", obs, ev(SCATTER, 1'b0, 1'b0, 3'd0));
    cycle();
    chk("rel_pulse", obs, ev(SCATTER, 1'b1, 1'b0, 3'd0));

    // Timetable 4,6,4,6,3,6,3 then endless phase 7 chase, no further reload
    for (int k = 1; k <= 40; k++) begin
      int cnt;
      cnt = 0;
      cycle();
      for (int j = 0; j < 7; j++)
        if (k >= cum[j]) cnt++;
      chk("timetable", obs, ev(cnt[0] ? CHASE : SCATTER, 1'b0, 1'b0, 3'(cnt)));
    end

    // GAMEOVER for one cycle clears everything; release restarts from 2
    bus.i_game_state = GS_GAMEOVER;
    cycle();
    chk("clear", obs, ev(SCATTER, 1'b0, 1'b0, 3'd0));
    bus.i_game_state = GS_PLAY;
    cycle();
    chk("rel2_tick1", obs, ev(SCATTER, 1'b0, 1'b0, 3'd0));
    cycle();
    chk("rel2_pulse", obs, ev(SCATTER, 1'b1, 1'b0, 3'd0));
    repeat (3) cycle();
    chk("ph0_end", obs, ev(SCATTER, 1'b0, 1'b0, 3'd0));
    cycle();
    chk("ph1_entry", obs, ev(CHASE, 1'b0, 1'b0, 3'd1));
    repeat (3) cycle();
    chk("ph1_3left", obs, ev(CHASE, 1'b0, 1'b0, 3'd1));

    // Pellet in phase 1 with 3 schedule ticks left (no tick on pellet cycle)
    bus.i_power_pellet = 1'b1;
    bus.i_tick = 1'b0;
    cycle();
    bus.i_power_pellet = 1'b0;
    bus.i_tick = 1'b1;
    chk("fr_load", obs, ev(FRIGHTENED, 1'b0, 1'b0, 3'd1));
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("fr_run", obs, ev(FRIGHTENED, 1'b0, fl_exp[i], 3'd1));
    end
    cycle();
    chk("fr_end", obs, ev(CHASE, 1'b0, 1'b0, 3'd1));
    repeat (2) cycle();
    chk("ph1_resume", obs, ev(CHASE, 1'b0, 1'b0, 3'd1));
    cycle();
    chk("ph2_entry", obs, ev(SCATTER, 1'b0, 1'b0, 3'd2));
    repeat (3) cycle();
    chk("ph2_end", obs, ev(SCATTER, 1'b0, 1'b0, 3'd2));
    cycle();
    chk("ph3_entry", obs, ev(CHASE, 1'b0, 1'b0, 3'd3));

    // Re-trigger on the third fright tick: one CHASE cycle, then FRIGHTENED
    bus.i_power_pellet = 1'b1;
    bus.i_tick = 1'b0;
    cycle();
    bus.i_power_pellet = 1'b0;
    bus.i_tick = 1'b1;
    chk("fr2_load", obs, ev(FRIGHTENED, 1'b0, 1'b0, 3'd3));
    repeat (2) cycle();
    chk("fr2_tick2", obs, ev(FRIGHTENED, 1'b0, 1'b0, 3'd3));
    bus.i_power_pellet = 1'b1;
    cycle();
    bus.i_power_pellet = 1'b0;
    chk("retrig_gap", obs, ev(CHASE, 1'b0, 1'b0, 3'd3));
    cycle();
    chk("retrig_fr", obs, ev(FRIGHTENED, 1'b0, 1'b0, 3'd3));
    cycle();
    chk("retrig_fr2", obs, ev(FRIGHTENED, 1'b0, 1'b0, 3'd3));

    // PAUSE for 10 cycles with ticks and a pellet pulse: nothing moves
    bus.i_game_state = GS_PAUSE;
    for (int i = 0; i < 10; i++) begin
      bus.i_power_pellet = (i == 4);
      cycle();
      chk("pause_hold", obs, ev(FRIGHTENED, 1'b0, 1'b0, 3'd3));
    end
    bus.i_power_pellet = 1'b0;
    bus.i_game_state = GS_PLAY;
    cycle();
    chk("resume_fl1", obs, ev(FRIGHTENED, 1'b0, 1'b1, 3'd3));
    cycle();
    chk("resume_fl2", obs, ev(FRIGHTENED, 1'b0, 1'b1, 3'd3));
    cycle();
    chk("resume_end", obs, ev(CHASE, 1'b0, 1'b0, 3'd3));
    repeat (5) cycle();
    chk("ph3_last", obs, ev(CHASE, 1'b0, 1'b0, 3'd3));
    cycle();
    chk("ph4_entry", obs, ev(SCATTER, 1'b0, 1'b0, 3'd4));
    repeat (3) cycle();
    chk("ph5_entry", obs, ev(CHASE, 1'b0, 1'b0, 3'd5));
    cycle();
    chk("ph5_run", obs, ev(CHASE, 1'b0, 1'b0, 3'd5));

    // Asynchronous reset mid-chase, sampled before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("async_rst", obs, ev(SCATTER, 1'b0, 1'b0, 3'd0));
    @(negedge clk);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
